// File: rtl/srl32_chain_top.sv
// srl32_chain_top: LFSR-fed SRL32 cascade self-test with sticky error / active LEDs (optional SRL_ERR_INJECT_EN: sw[k] flips chain k input)
module srl32_chain_top #(
    parameter int          NUM_CHAINS = 8,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    input  logic [15:0] sw,
    output logic [15:0] led
);
    logic [15:0] cnt = '0;
    logic [7:0]  err_v;
    logic [7:0]  act_v;
    logic        unused_sw;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    assign tx        = rx;
    assign unused_sw = ^sw;
    assign led       = {act_v, err_v};

    // cycle counter since power-up / reset, saturating so late checks stay enabled
    always_ff @(posedge clk) cnt <= rst ? '0 : (&cnt ? cnt : cnt + 16'd1);

    genvar k, j;
    for (k = 0; k < 8; k++) begin : g_chain
        if (k < NUM_CHAINS) begin : g_used
            localparam int          N = k + 1;
            localparam logic [15:0] L = 16'(32 * N);
            localparam logic [15:0] S = SEED ^ 16'(k);
            logic [15:0] gen = S;
            logic [15:0] chk = S;
            logic        err = 1'b0;
            logic        act = 1'b0;
            logic [N:0]  link;
            logic        inj;
`ifdef SRL_ERR_INJECT_EN
            assign inj = sw[k];
`else
            assign inj = 1'b0;
`endif
            assign link[0] = gen[0] ^ inj;
            for (j = 0; j < N; j++) begin : g_stage
                logic [31:0] sr = '0;
                // SRL32 stage: shifts every clock, no reset, tap 31 feeds the next stage
                always_ff @(posedge clk) sr <= {sr[30:0], link[j]};
                assign link[j+1] = sr[31];
            end
            // generator, latency-aligned reference and flags; reference waits L cycles before advancing
            always_ff @(posedge clk) begin
                if (rst) begin
                    gen <= S;
                    chk <= S;
                    err <= 1'b0;
                    act <= 1'b0;
                end else begin
                    gen <= lfsr_next(gen);
                    chk <= (cnt >= L) ? lfsr_next(chk) : chk;
                    act <= cnt >= L - 16'd1;
                    err <= err | (act & (link[N] ^ chk[0]));
                end
            end
            assign err_v[k] = err;
            assign act_v[k] = act;
        end else begin : g_unused
            assign err_v[k] = 1'b0;
            assign act_v[k] = 1'b0;
        end
    end
endmodule

// File: tb/tb_srl32_chain_top.sv
// tb_srl32_chain_top: directed bench checking LED timing, reset, error flags and UART loopback
module tb_srl32_chain_top;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        tx;
    logic [15:0] sw  = '0;
    logic [15:0] led;
    logic [15:0] exp_led;
    int          vecs = 0;
    int          errs = 0;
    int          base = 0;

    srl32_chain_top dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx),
        .sw (sw),
        .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        for (int cyc = 1; cyc <= 50000; cyc++) begin
            @(negedge clk);
            exp_led = '0;
            for (int k = 0; k < 8; k++) exp_led[8+k] = (cyc - base) >= 32 * (k + 1);
`ifdef SRL_ERR_INJECT_EN
            if (cyc >= 629 && cyc <= 1000) exp_led[3] = 1'b1;
`endif
            vecs++;
            assert (led === exp_led) else begin
                errs++;
                $error("FAIL led cyc=%0d observed=%h expected=%h", cyc, led, exp_led);
            end
            rst = (cyc == 1000);
            if (cyc == 1000) base = 1001;
`ifdef SRL_ERR_INJECT_EN
            sw = (cyc == 500) ? 16'h0008 : 16'h0000;
`else
            sw = (cyc >= 2000 && cyc < 3000) ? 16'hFFFF : 16'h0000;
`endif
            if (cyc >= 3000 && cyc < 3064) begin
                rx = cyc[0];
                #1;
                vecs++;
                assert (tx === rx) else begin
                    errs++;
                    $error("FAIL tx cyc=%0d observed=%b expected=%b", cyc, tx, rx);
                end
            end
        end
        rx = 1'b1;
        #1;
        vecs++;
        assert (tx === 1'b1) else begin
            errs++;
            $error("FAIL tx_idle observed=%b expected=1", tx);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/srl32_chain_top.md
Name: srl32_chain_top

Overview:
- Self-checking test block for chains of 32-bit shift-register (SRL32) primitives, intended to map onto SRLC32E cascades.
- Each of 8 independent chains is fed by a 16-bit LFSR pattern generator; a time-aligned reference LFSR checks the chain output every cycle.
- Results are shown on the board LEDs: led[7:0] are sticky per-chain error flags, led[15:8] are per-chain "checking active" flags.

Parameters:
- NUM_CHAINS, 8, number of independent chains; must be ≤ 8, one error LED and one active LED each.
- SEED, 16'hACE1, base LFSR seed; chain k uses SEED ^ k, which must be nonzero.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset; may be tied 0.
- rx  input  1  UART receive, unused except for loopback.
- tx  output  1  UART transmit; equals rx combinationally.
- sw  input  16  switches; used only with the optional feature.
- led  output  16  [7:0] sticky error flags, [15:8] checking-active flags.

Behaviour:
- Every register has an initial value equal to its reset value, so the design self-starts with rst tied low and no reset pulse.
- Cycle t=0 is the first cycle after power-up or after rst deasserts.
- Chain k (k = 0..NUM_CHAINS-1) consists of k+1 cascaded SRL32 stages.
  - Each stage is a 32-bit shift register that shifts every clock, addressed at tap 31, giving exactly 32 cycles of delay.
  - The stage output is combinational from register bit 31; the cascade uses bit 31 as the next stage's input.
  - Total latency L_k = 32*(k+1).
  - SRL contents have no reset; the initial value is all zeros.
- Generator k:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, loaded with SEED^k on reset.
  - Advances every cycle; bit 0 is shifted into the chain, so g_k(t) = gen_k[0] during cycle t.
- Cycle counter:
  - 16-bit, saturating at its maximum value.
  - Cleared to 0 by reset; increments every cycle.
- Checker k:
  - Reference LFSR with the same polynomial and seed; holds its seed while counter < L_k.
  - Advances every cycle from counter == L_k onward, so its bit 0 = g_k(t-L_k).
  - active_k = (counter >= L_k). While active_k, if chain output != ref_k[0], err_k is set on the next edge.
  - err_k is sticky until reset; reset clears err_k and active_k.
- Unused chain slots (k ≥ NUM_CHAINS) drive their led bits to 0.
- led[k] = err_k, led[8+k] = active_k, both registered.
- Reset asserted mid-operation takes effect on the next edge:
  - clears generators, checkers, counter and flags;
  - the shift-register contents are not cleared; stale data is harmless because checking restarts only after L_k new cycles.

Optional Feature:
- Macro SRL_ERR_INJECT_EN.
  - Defined: the bit entering chain k is g_k(t) XOR sw[k], allowing error injection from the switches.
  - Undefined: sw is ignored entirely, and the module behaves as if sw = 0.

Test Plan:
- rst=0 throughout, sw=0, rx=1, run 50000 cycles → led[7:0]==0 on every clock edge; tx==1.
- Power-up timing → led[8+k] rises in cycle 32(k+1) (led[8] at cycle 32, led[15] at cycle 256) and stays high.
- Reset pulse at cycle 1000 for 1 cycle → led[15:0]==0 the next cycle; led[8] returns after 32 cycles; led[7:0] stays 0.
- With SRL_ERR_INJECT_EN, set sw[3]=1 for one cycle at cycle 500 → led[3] sets at cycle 500+128+1 and remains set; all other error flags stay 0; a reset clears it.
- Without SRL_ERR_INJECT_EN, sw=16'hFFFF → led[7:0] stays 0.
- Toggle rx → tx follows in the same cycle.
